// File: rtl/alsu_arbiter.sv
// alsu_arbiter: two-port round-robin front end sharing one ALSU.
// One command in flight; the result goes back to the port that issued it.

module alsu_arbiter #(
  parameter int ALSU_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req1_valid,
  output logic              req0_ready,
  output logic              req1_ready,
  input  logic [15:0]       req0_cmd,
  input  logic [15:0]       req1_cmd,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  input  logic              rsp0_ready,
  input  logic              rsp1_ready,
  output logic signed [5:0] rsp_data,
  output logic              rsp_err,
  output logic [2:0]        alsu_opcode,
  output logic signed [2:0] alsu_A,
  output logic signed [2:0] alsu_B,
  output logic              alsu_cin,
  output logic              alsu_serial_in,
  output logic              alsu_direction,
  output logic              alsu_red_op_A,
  output logic              alsu_red_op_B,
  output logic              alsu_bypass_A,
  output logic              alsu_bypass_B,
  input  logic signed [5:0] alsu_out,
  input  logic [15:0]       alsu_leds,
  output logic              busy,
  output logic [7:0]        err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(ALSU_LAT);

  state_t      state;
  logic        owner;
  logic        last_grant;
  logic [2:0]  cnt;
  logic        gnt0;
  logic        gnt1;
  logic [15:0] cmd;
  logic        rsp_take;
  logic        err_now;

  // Round-robin grant, offered only while idle; ties go to the
  // port that did not win last time.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || last_grant))
        gnt0 = 1'b1;
      else if (req1_valid)
        gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign cmd        = gnt1 ? req1_cmd : req0_cmd;
  assign busy       = (state != IDLE);
  assign rsp_take   = owner ? rsp1_ready : rsp0_ready;
  assign err_now    = |alsu_leds;

  // Sequencer: load ALSU controls, wait out its latency, hold result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;
      cnt            <= '0;
      rsp0_valid     <= 1'b0;
      rsp1_valid     <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      err_cnt        <= '0;
      alsu_opcode    <= '0;
      alsu_A         <= '0;
      alsu_B         <= '0;
      alsu_cin       <= 1'b0;
      alsu_serial_in <= 1'b0;
      alsu_direction <= 1'b0;
      alsu_red_op_A  <= 1'b0;
      alsu_red_op_B  <= 1'b0;
      alsu_bypass_A  <= 1'b0;
      alsu_bypass_B  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            alsu_opcode    <= cmd[15:13];
            alsu_A         <= cmd[12:10];
            alsu_B         <= cmd[9:7];
            alsu_cin       <= cmd[6];
            alsu_serial_in <= cmd[5];
            alsu_direction <= cmd[4];
            alsu_red_op_A  <= cmd[3];
            alsu_red_op_B  <= cmd[2];
            alsu_bypass_A  <= cmd[1];
            alsu_bypass_B  <= cmd[0];
            owner          <= gnt1;
            last_grant     <= gnt1;
            cnt            <= LAT;
            state          <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            rsp_data   <= alsu_out;
            rsp_err    <= err_now;
            rsp0_valid <= !owner;
            rsp1_valid <= owner;
            state      <= RESP;
            if (err_now && (err_cnt != 8'hFF))
              err_cnt <= err_cnt + 8'd1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_take) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_arbiter.sv
// tb_alsu_arbiter: scoreboard bench with a behavioural ALSU pipeline.
// Main instance uses latency 2; latency 1 and 4 instances share stimulus.

module tb_alsu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [15:0] req0_cmd = '0;
  logic [15:0] req1_cmd = '0;
  logic        rsp0_ready = 1'b0;
  logic        rsp1_ready = 1'b0;

  // latency-2 instance
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [5:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] av;
  logic [5:0]  alsu_out;
  logic [15:0] alsu_leds;
  logic        busy;
  logic [7:0]  err_cnt;

  // latency-1 instance
  logic        r0r_l1, r1r_l1, s0v_l1, s1v_l1, e_l1, busy_l1;
  logic [5:0]  d_l1, ao_l1;
  logic [15:0] av_l1, al_l1;
  logic [7:0]  ec_l1;

  // latency-4 instance
  logic        r0r_l4, r1r_l4, s0v_l4, s1v_l4, e_l4, busy_l4;
  logic [5:0]  d_l4, ao_l4;
  logic [15:0] av_l4, al_l4;
  logic [7:0]  ec_l4;

  alsu_arbiter #(.ALSU_LAT(2)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alsu_opcode(av[15:13]), .alsu_A(av[12:10]), .alsu_B(av[9:7]),
    .alsu_cin(av[6]), .alsu_serial_in(av[5]), .alsu_direction(av[4]),
    .alsu_red_op_A(av[3]), .alsu_red_op_B(av[2]),
    .alsu_bypass_A(av[1]), .alsu_bypass_B(av[0]),
    .alsu_out(alsu_out), .alsu_leds(alsu_leds),
    .busy(busy), .err_cnt(err_cnt)
  );

  alsu_arbiter #(.ALSU_LAT(1)) u_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(r0r_l1), .req1_ready(r1r_l1),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .rsp0_valid(s0v_l1), .rsp1_valid(s1v_l1),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(d_l1), .rsp_err(e_l1),
    .alsu_opcode(av_l1[15:13]), .alsu_A(av_l1[12:10]), .alsu_B(av_l1[9:7]),
    .alsu_cin(av_l1[6]), .alsu_serial_in(av_l1[5]), .alsu_direction(av_l1[4]),
    .alsu_red_op_A(av_l1[3]), .alsu_red_op_B(av_l1[2]),
    .alsu_bypass_A(av_l1[1]), .alsu_bypass_B(av_l1[0]),
    .alsu_out(ao_l1), .alsu_leds(al_l1),
    .busy(busy_l1), .err_cnt(ec_l1)
  );

  alsu_arbiter #(.ALSU_LAT(4)) u_l4 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(r0r_l4), .req1_ready(r1r_l4),
    .req0_cmd(req0_cmd), .req1_cmd(req1_cmd),
    .rsp0_valid(s0v_l4), .rsp1_valid(s1v_l4),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(d_l4), .rsp_err(e_l4),
    .alsu_opcode(av_l4[15:13]), .alsu_A(av_l4[12:10]), .alsu_B(av_l4[9:7]),
    .alsu_cin(av_l4[6]), .alsu_serial_in(av_l4[5]), .alsu_direction(av_l4[4]),
    .alsu_red_op_A(av_l4[3]), .alsu_red_op_B(av_l4[2]),
    .alsu_bypass_A(av_l4[1]), .alsu_bypass_B(av_l4[0]),
    .alsu_out(ao_l4), .alsu_leds(al_l4),
    .busy(busy_l4), .err_cnt(ec_l4)
  );

  // behavioural ALSU: {error, signed result} from a packed command
  function automatic logic [6:0] alsu_f(input logic [15:0] c);
    logic signed [5:0] a, b, r;
    logic e;
    a = {{3{c[12]}}, c[12:10]};
    b = {{3{c[9]}}, c[9:7]};
    e = 1'b0;
    case (c[15:13])
      3'd0: r = a & b;
      3'd1: r = a ^ b;
      3'd2: r = a + b + {5'd0, c[6]};
      3'd3: r = a * b;
      3'd4: r = {a[4:0], c[5]};
      3'd5: r = c[4] ? {b[4:0], c[5]} : {c[5], b[5:1]};
      default: begin r = '0; e = 1'b1; end
    endcase
    if (!e && c[1]) r = a;
    if (!e && c[0]) r = b;
    return {e, r};
  endfunction

  logic [6:0] p1;
  logic [6:0] p2 [2];
  logic [6:0] p4 [4];

  // ALSU register stages, cleared by the shared reset
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      p1 <= '0;
      for (int i = 0; i < 2; i++) p2[i] <= '0;
      for (int i = 0; i < 4; i++) p4[i] <= '0;
    end else begin
      p1    <= alsu_f(av_l1);
      p2[0] <= alsu_f(av);
      p2[1] <= p2[0];
      p4[0] <= alsu_f(av_l4);
      for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
    end
  end

  assign alsu_out  = p2[1][5:0];
  assign alsu_leds = {16{p2[1][6]}};
  assign ao_l1     = p1[5:0];
  assign al_l1     = {16{p1[6]}};
  assign ao_l4     = p4[3][5:0];
  assign al_l4     = {16{p4[3][6]}};

  typedef struct {
    int         port;
    logic [5:0] data;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] tbl [8] = '{16'h4A00, 16'h2C40, 16'h0D8C, 16'h6B00,
                           16'h8A20, 16'hA710, 16'h4F42, 16'h3381};

  function automatic void push_exp(input int port, input logic [15:0] c);
    logic [6:0] f;
    f = alsu_f(c);
    exp_q.push_back('{port, f[5:0], f[6]});
  endfunction

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset      = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // offer cmd on a port until granted, then record the expected result
  task automatic send(input int port, input logic [15:0] c);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk);
    #1;
    if (port == 1) begin req1_cmd = c; req1_valid = 1'b1; end
    else begin req0_cmd = c; req0_valid = 1'b1; end
    while (!ok && n < 40) begin
      @(negedge clk);
      n++;
      ok = (port == 1) ? req1_ready : req0_ready;
      if (!ok) @(posedge clk);
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_ready: port %0d got no ready, want ready within 40", port);
    end
    @(posedge clk);
    if (ok) push_exp(port, c);
    #1;
    if (port == 1) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  // wait for the next response and score it against the queue head
  task automatic expect_rsp(input int budget, output int waited);
    int n;
    bit got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (!got && n < budget) begin
      @(negedge clk);
      n++;
      got = rsp0_valid || rsp1_valid;
    end
    waited = n;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL rsp_timeout: got none, want a response within %0d", budget);
    end else if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL rsp_extra: got a response, want none queued");
    end else begin
      e      = exp_q.pop_front();
      last_e = e;
      n_cmp += 3;
      if ({rsp1_valid, rsp0_valid} !== ((e.port == 1) ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL rsp_port: got %b, want port %0d", {rsp1_valid, rsp0_valid}, e.port);
      end
      if (rsp_data !== e.data) begin
        n_bad++;
        $display("FAIL rsp_data: got %h want %h", rsp_data, e.data);
      end
      if (rsp_err !== e.err) begin
        n_bad++;
        $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_cmp += 6;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
      n_bad++; $display("FAIL rst_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid});
    end
    if ({rsp_err, rsp_data} !== 7'd0) begin
      n_bad++; $display("FAIL rst_rsp: got %h want 0", {rsp_err, rsp_data});
    end
    if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d want 0", err_cnt); end
    if (av !== 16'h0000) begin n_bad++; $display("FAIL rst_alsu: got %h want 0000", av); end
    if ({req1_ready, req0_ready} !== 2'b00) begin
      n_bad++; $display("FAIL rst_ready: got %b want 00", {req1_ready, req0_ready});
    end
  endtask

  task automatic test_single();
    int w;
    apply_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(posedge clk);
    #1;
    req0_cmd   = 16'h4A00;
    req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL single_ready: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk);
    push_exp(0, 16'h4A00);
    #1 req0_valid = 1'b0;
    expect_rsp(20, w);
    n_cmp += 4;
    if (w !== 4) begin n_bad++; $display("FAIL single_latency: got T+%0d want T+4", w); end
    if (rsp_data !== 6'b111110) begin
      n_bad++; $display("FAIL single_data: got %b want 111110", rsp_data);
    end
    if (av !== 16'h4A00) begin n_bad++; $display("FAIL single_alsu: got %h want 4A00", av); end
    if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    @(negedge clk);
    n_cmp++;
    if ({busy, rsp1_valid, rsp0_valid} !== 3'b000) begin
      n_bad++; $display("FAIL single_done: got %b want 000", {busy, rsp1_valid, rsp0_valid});
    end
  endtask

  task automatic test_latency();
    int t1, t2, t4;
    logic [5:0] d1, d2, d4;
    logic [6:0] f;
    t1 = -1; t2 = -1; t4 = -1;
    d1 = 'x; d2 = 'x; d4 = 'x;
    f  = alsu_f(16'h4A00);
    apply_reset();
    rsp0_ready = 1'b1;
    @(posedge clk);
    #1;
    req0_cmd   = 16'h4A00;
    req0_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({r0r_l1, req0_ready, r0r_l4} !== 3'b111) begin
      n_bad++; $display("FAIL lat_ready: got %b want 111", {r0r_l1, req0_ready, r0r_l4});
    end
    @(posedge clk);
    #1 req0_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (s0v_l1 && t1 < 0) begin t1 = k; d1 = d_l1; end
      if (rsp0_valid && t2 < 0) begin t2 = k; d2 = rsp_data; end
      if (s0v_l4 && t4 < 0) begin t4 = k; d4 = d_l4; end
    end
    n_cmp += 4;
    if (t1 !== 3) begin n_bad++; $display("FAIL lat1_valid: got T+%0d want T+3", t1); end
    if (t2 !== 4) begin n_bad++; $display("FAIL lat2_valid: got T+%0d want T+4", t2); end
    if (t4 !== 6) begin n_bad++; $display("FAIL lat4_valid: got T+%0d want T+6", t4); end
    if ({d1, d2, d4} !== {3{f[5:0]}}) begin
      n_bad++; $display("FAIL lat_data: got %h %h %h want %h", d1, d2, d4, f[5:0]);
    end
  endtask

  task automatic test_alternate();
    int ports[$];
    int cycs[$];
    int acc, idx, w, g;
    bit both, chk;
    logic [15:0] pend;
    exp_t e;
    apply_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    both = 1'b0;
    chk  = 1'b0;
    pend = '0;
    idx  = 2;
    @(posedge clk);
    #1;
    req0_cmd   = tbl[0];
    req1_cmd   = tbl[1];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int c = 0; c < 33; c++) begin
      @(negedge clk);
      if (chk) begin
        n_cmp++;
        if (av !== pend) begin n_bad++; $display("FAIL alt_alsu: got %h want %h", av, pend); end
        chk = 1'b0;
      end
      if (req0_ready && req1_ready) both = 1'b1;
      if (rsp0_valid || rsp1_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL alt_extra: got a response, want none queued");
        end else begin
          e = exp_q.pop_front();
          if ({rsp1_valid, rsp0_valid, rsp_err, rsp_data} !==
              {(e.port == 1), (e.port == 0), e.err, e.data}) begin
            n_bad++;
            $display("FAIL alt_rsp: got %b/%b/%h want port %0d/%b/%h",
                     {rsp1_valid, rsp0_valid}, rsp_err, rsp_data, e.port, e.err, e.data);
          end
        end
      end
      acc = -1;
      if (req0_valid && req0_ready) acc = 0;
      else if (req1_valid && req1_ready) acc = 1;
      if (acc >= 0) begin
        ports.push_back(acc);
        cycs.push_back(c);
        pend = (acc == 1) ? req1_cmd : req0_cmd;
        push_exp(acc, pend);
        chk = 1'b1;
      end
      @(posedge clk);
      #1;
      if (acc == 0) begin req0_cmd = tbl[idx % 8]; idx++; end
      if (acc == 1) begin req1_cmd = tbl[idx % 8]; idx++; end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    g = 0;
    while (exp_q.size() > 0 && g < 4) begin
      expect_rsp(20, w);
      g++;
    end
    n_cmp += 2;
    if (both) begin n_bad++; $display("FAIL alt_both_ready: got both, want one"); end
    if (ports.size() < 6) begin
      n_bad++; $display("FAIL alt_count: got %0d accepts, want >= 6", ports.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (ports[i] !== (i % 2)) begin
          n_bad++; $display("FAIL alt_order: accept %0d got port %0d want %0d", i, ports[i], i % 2);
        end
        if (i > 0) begin
          n_cmp++;
          if (cycs[i] - cycs[i-1] !== 5) begin
            n_bad++; $display("FAIL alt_period: got %0d want 5", cycs[i] - cycs[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    apply_reset();
    rsp1_ready = 1'b1;
    send(0, tbl[3]);
    req1_cmd   = tbl[4];
    req1_valid = 1'b1;
    expect_rsp(20, w);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp += 4;
      if (rsp0_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", rsp0_valid); end
      if (rsp_data !== last_e.data) begin
        n_bad++; $display("FAIL bp_data: got %h want %h", rsp_data, last_e.data);
      end
      if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_busy: got %b want 1", busy); end
      if (req1_ready !== 1'b0) begin n_bad++; $display("FAIL bp_req1_ready: got %b want 0", req1_ready); end
    end
    rsp0_ready = 1'b1;
    @(posedge clk);
    #1 rsp0_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({req1_ready, rsp0_valid} !== 2'b10) begin
      n_bad++; $display("FAIL bp_release: got %b want 10", {req1_ready, rsp0_valid});
    end
    @(posedge clk);
    push_exp(1, tbl[4]);
    #1 req1_valid = 1'b0;
    expect_rsp(20, w);
    n_cmp++;
    if (w !== 4) begin n_bad++; $display("FAIL bp_req1_latency: got T+%0d want T+4", w); end
  endtask

  task automatic test_errors();
    int n, w;
    apply_reset();
    rsp1_ready = 1'b1;
    n = 0;
    @(posedge clk);
    #1;
    req1_cmd   = 16'hC000;
    req1_valid = 1'b1;
    for (int k = 0; k < 2000 && n < 256; k++) begin
      @(negedge clk);
      if (rsp1_valid) begin
        n++;
        if (n == 1 || n == 255 || n == 256) begin
          n_cmp += 2;
          if (rsp_err !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b want 1", rsp_err); end
          if (err_cnt !== ((n == 1) ? 8'd1 : 8'd255)) begin
            n_bad++; $display("FAIL err_cnt_%0d: got %0d want %0d", n, err_cnt, (n == 1) ? 1 : 255);
          end
        end
        if (n == 256) req1_valid = 1'b0;
      end
    end
    req1_valid = 1'b0;
    n_cmp++;
    if (n !== 256) begin n_bad++; $display("FAIL err_count_rsps: got %0d want 256", n); end
    send(1, tbl[0]);
    expect_rsp(20, w);
    n_cmp++;
    if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL err_cnt_hold: got %0d want 255", err_cnt); end
  endtask

  task automatic test_reset_abort();
    int w;
    bit seen;
    apply_reset();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    send(1, 16'hC000);
    expect_rsp(20, w);
    @(posedge clk);
    #1;
    req0_cmd   = tbl[0];
    req0_valid = 1'b1;
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_cmp += 3;
    if ({busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready} !== 5'b0) begin
      n_bad++;
      $display("FAIL abort_ctl: got %b want 00000",
               {busy, rsp1_valid, rsp0_valid, req1_ready, req0_ready});
    end
    if (av !== 16'h0000) begin n_bad++; $display("FAIL abort_alsu: got %h want 0000", av); end
    if ({err_cnt, rsp_err, rsp_data} !== 15'd0) begin
      n_bad++; $display("FAIL abort_rsp: got %0d/%b/%h want 0/0/00", err_cnt, rsp_err, rsp_data);
    end
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin n_bad++; $display("FAIL abort_ghost: got activity, want none"); end
    @(posedge clk);
    #1;
    req0_cmd   = tbl[5];
    req1_cmd   = tbl[6];
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_bad++; $display("FAIL abort_first_grant: got %b want 01", {req1_ready, req0_ready});
    end
    @(posedge clk);
    push_exp(0, tbl[5]);
    #1 req0_valid = 1'b0;
    expect_rsp(20, w);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL abort_second_grant: got %b want 1", req1_ready); end
    @(posedge clk);
    push_exp(1, tbl[6]);
    #1 req1_valid = 1'b0;
    expect_rsp(20, w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_latency();
    test_alternate();
    test_backpressure();
    test_errors();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
